// File: rtl/addsub_dx_pkg.sv
// Shared types and constants for the duplex add/sub arbiter.
// Op-mode bundle and response tag encodings.
package addsub_dx_pkg;

  typedef struct packed {
    logic addsub;
    logic sat;
    logic avg;
    logic tc;
    logic ci;
    logic half;
  } op_mode_t;

  localparam logic [1:0] TAG_R0   = 2'b01;
  localparam logic [1:0] TAG_R1   = 2'b10;
  localparam logic [1:0] TAG_PAIR = 2'b11;

  function automatic logic same_mode(
    input op_mode_t x,
    input op_mode_t y
  );
    return {x.addsub, x.sat, x.avg, x.tc}
        == {y.addsub, y.sat, y.avg, y.tc};
  endfunction

endpackage

// File: rtl/addsub_dx_rr2.sv
// Two-way round-robin grant with a pairing override.
// Pointer moves to the loser only on a real, non-paired issue.
module addsub_dx_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       pair_ok_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output logic       ptr_o
);

  logic ptr_q, ptr_d;
  logic pick0, pick1;

  assign pick1 = ~pair_ok_i &
    (ptr_q ? valid_i[1]
           : (~valid_i[0] & valid_i[1]));
  assign pick0 = ~pair_ok_i & ~pick1 & valid_i[0];

  always_comb begin
    grant_o = 2'b00;
    unique case (1'b1)
      pair_ok_i: grant_o = 2'b11;
      pick1:     grant_o = 2'b10;
      pick0:     grant_o = 2'b01;
      default: ;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i & ~pair_ok_i & |grant_o)
      ptr_d = grant_o[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/addsub_dx_arb.sv
// Two-requester issue/response sequencer for a duplex add/sub datapath.
// Pair counter exists only with ADDSUB_DX_ARB_PERF_EN defined.
module addsub_dx_arb
  import addsub_dx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int P1_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req0_addsub,
  input  logic                 req0_sat,
  input  logic                 req0_avg,
  input  logic                 req0_tc,
  input  logic                 req0_ci,
  input  logic                 req0_half,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic                 req1_addsub,
  input  logic                 req1_sat,
  input  logic                 req1_avg,
  input  logic                 req1_tc,
  input  logic                 req1_ci,
  input  logic                 req1_half,
  output logic [WIDTH-1:0]     dp_a,
  output logic [WIDTH-1:0]     dp_b,
  output logic                 dp_addsub,
  output logic                 dp_sat,
  output logic                 dp_avg,
  output logic                 dp_tc,
  output logic                 dp_dplx,
  output logic                 dp_ci1,
  output logic                 dp_ci2,
  input  logic [WIDTH-1:0]     dp_sum,
  input  logic                 dp_co1,
  input  logic                 dp_co2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic                 rsp_co1,
  output logic                 rsp_co2,
  output logic [1:0]           rsp_tag,
  output logic                 rsp_dplx,
  output logic [CNT_WIDTH-1:0] pair_cnt
);

  localparam int P2_WIDTH = WIDTH - P1_WIDTH;

  op_mode_t m0, m1, ms;
  logic [1:0] grant;
  logic       pair_ok, rr_ptr_unused;
  logic       r_free, i_adv, can_issue, issue;

  logic             i_valid_q;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
  logic             addsub_q, sat_q, avg_q, tc_q;
  logic             dplx_q, ci1_q, ci2_q;
  logic             dplx_d, ci1_d, ci2_d;
  logic [1:0]       tag_q, tag_d;

  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_co1_q, rsp_co2_q, rsp_dplx_q;
  logic [1:0]       rsp_tag_q;

  assign m0 = {req0_addsub, req0_sat, req0_avg,
               req0_tc, req0_ci, req0_half};
  assign m1 = {req1_addsub, req1_sat, req1_avg,
               req1_tc, req1_ci, req1_half};

  assign pair_ok = req0_valid & req1_valid &
                   m0.half & m1.half &
                   same_mode(m0, m1);

  assign r_free    = ~rsp_valid_q | rsp_ready;
  assign i_adv     = i_valid_q & r_free;
  assign can_issue = ~i_valid_q | r_free;
  assign issue     = can_issue & |grant;

  addsub_dx_rr2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   ({req1_valid, req0_valid}),
    .pair_ok_i (pair_ok),
    .advance_i (can_issue),
    .grant_o   (grant),
    .ptr_o     (rr_ptr_unused)
  );

  assign req0_ready = grant[0] & can_issue;
  assign req1_ready = grant[1] & can_issue;

  assign ms = grant[0] ? m0 : m1;

  // Half ops land in their own lane; the idle lane is zeroed.
  always_comb begin
    a_d    = '0;
    b_d    = '0;
    dplx_d = 1'b1;
    ci1_d  = 1'b0;
    ci2_d  = 1'b0;
    tag_d  = grant;
    unique case (1'b1)
      (grant == TAG_PAIR): begin
        a_d   = {req1_a[P2_WIDTH-1:0],
                 req0_a[P1_WIDTH-1:0]};
        b_d   = {req1_b[P2_WIDTH-1:0],
                 req0_b[P1_WIDTH-1:0]};
        ci1_d = m0.ci;
        ci2_d = m1.ci;
      end
      (grant == TAG_R0): begin
        if (ms.half) begin
          a_d = {{P2_WIDTH{1'b0}},
                 req0_a[P1_WIDTH-1:0]};
          b_d = {{P2_WIDTH{1'b0}},
                 req0_b[P1_WIDTH-1:0]};
        end else begin
          a_d    = req0_a;
          b_d    = req0_b;
          dplx_d = 1'b0;
        end
        ci1_d = ms.ci;
      end
      (grant == TAG_R1): begin
        if (ms.half) begin
          a_d   = {req1_a[P2_WIDTH-1:0],
                   {P1_WIDTH{1'b0}}};
          b_d   = {req1_b[P2_WIDTH-1:0],
                   {P1_WIDTH{1'b0}}};
          ci2_d = ms.ci;
        end else begin
          a_d    = req1_a;
          b_d    = req1_b;
          dplx_d = 1'b0;
          ci1_d  = ms.ci;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      addsub_q  <= 1'b0;
      sat_q     <= 1'b0;
      avg_q     <= 1'b0;
      tc_q      <= 1'b0;
      dplx_q    <= 1'b0;
      ci1_q     <= 1'b0;
      ci2_q     <= 1'b0;
      tag_q     <= 2'b00;
    end else begin
      if (can_issue) i_valid_q <= issue;
      if (issue) begin
        a_q      <= a_d;
        b_q      <= b_d;
        addsub_q <= ms.addsub;
        sat_q    <= ms.sat;
        avg_q    <= ms.avg;
        tc_q     <= ms.tc;
        dplx_q   <= dplx_d;
        ci1_q    <= ci1_d;
        ci2_q    <= ci2_d;
        tag_q    <= tag_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_co1_q   <= 1'b0;
      rsp_co2_q   <= 1'b0;
      rsp_tag_q   <= 2'b00;
      rsp_dplx_q  <= 1'b0;
    end else begin
      if (r_free) rsp_valid_q <= i_valid_q;
      if (i_adv) begin
        rsp_sum_q  <= dp_sum;
        rsp_co1_q  <= dp_co1;
        rsp_co2_q  <= dp_co2;
        rsp_tag_q  <= tag_q;
        rsp_dplx_q <= dplx_q;
      end
    end
  end

`ifdef ADDSUB_DX_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (issue & (grant == TAG_PAIR) & ~&cnt_q)
      cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign pair_cnt = cnt_q;
`else
  assign pair_cnt = '0;
`endif

  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_addsub = addsub_q;
  assign dp_sat    = sat_q;
  assign dp_avg    = avg_q;
  assign dp_tc     = tc_q;
  assign dp_dplx   = dplx_q;
  assign dp_ci1    = ci1_q;
  assign dp_ci2    = ci2_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_co1   = rsp_co1_q;
  assign rsp_co2   = rsp_co2_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_dplx  = rsp_dplx_q;

endmodule

// File: tb/tb_addsub_dx_arb.sv
// Bench for addsub_dx_arb: directed scenarios plus a randomized
// scoreboard run against a behavioural datapath/arbiter model.
module tb_addsub_dx_arb;

  typedef struct {
    logic [15:0] a, b;
    logic addsub, sat, avg, tc, ci, half;
  } rq_t;

  typedef struct {
    logic [15:0] dpa, dpb, sum;
    logic dplx, ci1, ci2, co1, co2;
    logic [1:0] tag;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0;
  logic req0_ready, req1_ready;
  logic [15:0] req0_a = 0, req0_b = 0;
  logic [15:0] req1_a = 0, req1_b = 0;
  logic req0_addsub = 0, req0_sat = 0, req0_avg = 0;
  logic req0_tc = 0, req0_ci = 0, req0_half = 0;
  logic req1_addsub = 0, req1_sat = 0, req1_avg = 0;
  logic req1_tc = 0, req1_ci = 0, req1_half = 0;
  logic [15:0] dp_a, dp_b, dp_sum;
  logic dp_addsub, dp_sat, dp_avg, dp_tc;
  logic dp_dplx, dp_ci1, dp_ci2, dp_co1, dp_co2;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [15:0] rsp_sum;
  logic rsp_co1, rsp_co2, rsp_dplx;
  logic [1:0] rsp_tag;
  logic [15:0] pair_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  addsub_dx_arb #(
    .WIDTH(16), .P1_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_addsub(req0_addsub), .req0_sat(req0_sat),
    .req0_avg(req0_avg), .req0_tc(req0_tc),
    .req0_ci(req0_ci), .req0_half(req0_half),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_addsub(req1_addsub), .req1_sat(req1_sat),
    .req1_avg(req1_avg), .req1_tc(req1_tc),
    .req1_ci(req1_ci), .req1_half(req1_half),
    .dp_a(dp_a), .dp_b(dp_b),
    .dp_addsub(dp_addsub), .dp_sat(dp_sat),
    .dp_avg(dp_avg), .dp_tc(dp_tc),
    .dp_dplx(dp_dplx), .dp_ci1(dp_ci1), .dp_ci2(dp_ci2),
    .dp_sum(dp_sum), .dp_co1(dp_co1), .dp_co2(dp_co2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_co1(rsp_co1), .rsp_co2(rsp_co2),
    .rsp_tag(rsp_tag), .rsp_dplx(rsp_dplx),
    .pair_cnt(pair_cnt)
  );

  // One lane of arithmetic, w bits wide: returns {carry, result}.
  function automatic logic [16:0] lane_op(
    input logic [15:0] a, b, input int w,
    input logic sub, sat, avg, tc, ci);
    longint mask, ua, ub, sa, sb, uv, sv, r, d, hi, lo, cl;
    mask = (longint'(1) << w) - 1;
    cl = 0;
    if (ci) cl = 1;
    ua = 0; ub = 0;
    ua[15:0] = a; ub[15:0] = b;
    ua = ua & mask; ub = ub & mask;
    sa = (ua > (mask >> 1)) ? ua - mask - 1 : ua;
    sb = (ub > (mask >> 1)) ? ub - mask - 1 : ub;
    uv = ua + (sub ? mask - ub : ub) + cl;
    sv = sa + (sub ? -sb - 1 : sb) + cl;
    hi = mask >> 1;
    lo = -hi - 1;
    if (avg) r = tc ? (sv >>> 1) : (uv >> 1);
    else if (sat && tc)
      r = (sv > hi) ? hi : ((sv < lo) ? lo : sv);
    else if (sat) begin
      d = sub ? uv - mask - 1 : uv;
      r = (d < 0) ? 0 : ((d > mask) ? mask : d);
    end else r = uv;
    r = r & mask;
    return {((uv >> w) & 1) != 0, r[15:0]};
  endfunction

  function automatic logic [17:0] dpm(
    input logic [15:0] a, b,
    input logic sub, sat, avg, tc, dplx, ci1, ci2);
    logic [16:0] l1, l2;
    if (dplx) begin
      l1 = lane_op({8'h0, a[7:0]}, {8'h0, b[7:0]}, 8,
                   sub, sat, avg, tc, ci1);
      l2 = lane_op({8'h0, a[15:8]}, {8'h0, b[15:8]}, 8,
                   sub, sat, avg, tc, ci2);
      return {l2[16], l1[16], l2[7:0], l1[7:0]};
    end
    l1 = lane_op(a, b, 16, sub, sat, avg, tc, ci1);
    return {1'b0, l1[16], l1[15:0]};
  endfunction

  always_comb
    {dp_co2, dp_co1, dp_sum} = dpm(dp_a, dp_b, dp_addsub,
      dp_sat, dp_avg, dp_tc, dp_dplx, dp_ci1, dp_ci2);

  function automatic ex_t predict(
    input rq_t r0, input rq_t r1, input logic [1:0] tag);
    ex_t e;
    rq_t m;
    logic [17:0] s;
    m = tag[0] ? r0 : r1;
    e.tag = tag;
    e.dplx = 1'b1; e.ci1 = 1'b0; e.ci2 = 1'b0;
    if (tag == 2'b11) begin
      e.dpa = {r1.a[7:0], r0.a[7:0]};
      e.dpb = {r1.b[7:0], r0.b[7:0]};
      e.ci1 = r0.ci; e.ci2 = r1.ci;
    end else if (!m.half) begin
      e.dpa = m.a; e.dpb = m.b;
      e.dplx = 1'b0; e.ci1 = m.ci;
    end else if (tag[0]) begin
      e.dpa = {8'h0, m.a[7:0]};
      e.dpb = {8'h0, m.b[7:0]};
      e.ci1 = m.ci;
    end else begin
      e.dpa = {m.a[7:0], 8'h0};
      e.dpb = {m.b[7:0], 8'h0};
      e.ci2 = m.ci;
    end
    s = dpm(e.dpa, e.dpb, m.addsub, m.sat, m.avg, m.tc,
            e.dplx, e.ci1, e.ci2);
    {e.co2, e.co1, e.sum} = s;
    return e;
  endfunction

  function automatic rq_t rnd_rq();
    rq_t r;
    logic [3:0] md;
    md = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
    r.a = 16'($urandom); r.b = 16'($urandom);
    {r.addsub, r.sat, r.avg, r.tc} = md;
    r.ci = 1'($urandom); r.half = 1'($urandom);
    return r;
  endfunction

  task automatic set0(input rq_t r);
    req0_a = r.a; req0_b = r.b; req0_addsub = r.addsub;
    req0_sat = r.sat; req0_avg = r.avg; req0_tc = r.tc;
    req0_ci = r.ci; req0_half = r.half;
  endtask

  task automatic set1(input rq_t r);
    req1_a = r.a; req1_b = r.b; req1_addsub = r.addsub;
    req1_sat = r.sat; req1_avg = r.avg; req1_tc = r.tc;
    req1_ci = r.ci; req1_half = r.half;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 0; req1_valid = 0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1 rst_n = 1'b0;
    #2;
    n_chk++;
    if ({rsp_valid, rsp_sum, rsp_tag, rsp_dplx} !== 20'h0)
      $display("FAIL reset_rsp: got %b %h %b %b exp zeros",
               rsp_valid, rsp_sum, rsp_tag, rsp_dplx);
    else n_pass++;
    n_chk++;
    if ({dp_a, dp_b, dp_dplx, dp_ci1, dp_ci2, dp_addsub}
        !== 36'h0)
      $display("FAIL reset_dp: got a=%h b=%h exp zeros",
               dp_a, dp_b);
    else n_pass++;
    n_chk++;
    if (pair_cnt !== 16'h0)
      $display("FAIL reset_cnt: got %h exp 0", pair_cnt);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_full_sat();
    rq_t r;
    do_reset();
    r = '{a:16'h7FFF, b:16'h0001, addsub:0, sat:1, avg:0,
          tc:1, ci:0, half:0};
    set0(r); req0_valid = 1;
    @(negedge clk);
    n_chk++;
    if (req0_ready !== 1'b1)
      $display("FAIL sat_ready: got %b exp 1", req0_ready);
    else n_pass++;
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    n_chk++;
    if ({dp_a, dp_dplx, dp_ci2, rsp_valid} !== {16'h7FFF, 3'b000})
      $display("FAIL sat_dp: got a=%h dplx=%b ci2=%b rv=%b",
               dp_a, dp_dplx, dp_ci2, rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_sum, rsp_tag} !== {1'b1, 16'h7FFF, 2'b01})
      $display("FAIL sat_rsp: got v=%b sum=%h tag=%b exp 1 7fff 01",
               rsp_valid, rsp_sum, rsp_tag);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0)
      $display("FAIL sat_drop: got %b exp 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_rr();
    rq_t r0, r1;
    ex_t e0, e1;
    do_reset();
    r0 = rnd_rq(); r0.half = 0; r0.addsub = 0;
    r1 = rnd_rq(); r1.half = 0; r1.addsub = 1;
    e0 = predict(r0, r1, 2'b01);
    e1 = predict(r0, r1, 2'b10);
    set0(r0); set1(r1); req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL rr_first: got %b exp 01",
               {req1_ready, req0_ready});
    else n_pass++;
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b10)
      $display("FAIL rr_second: got %b exp 10",
               {req1_ready, req0_ready});
    else n_pass++;
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_tag, rsp_sum, rsp_co1}
        !== {1'b1, 2'b01, e0.sum, e0.co1})
      $display("FAIL rr_rsp0: got tag=%b sum=%h exp 01 %h",
               rsp_tag, rsp_sum, e0.sum);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_tag, rsp_sum, rsp_co1}
        !== {1'b1, 2'b10, e1.sum, e1.co1})
      $display("FAIL rr_rsp1: got tag=%b sum=%h exp 10 %h",
               rsp_tag, rsp_sum, e1.sum);
    else n_pass++;
  endtask

  task automatic test_pair();
    rq_t r0, r1;
    logic [15:0] ecnt;
    do_reset();
    r0 = '{a:16'h0012, b:16'h0034, addsub:0, sat:0, avg:0,
           tc:0, ci:0, half:1};
    r1 = '{a:16'h0056, b:16'h0078, addsub:0, sat:0, avg:0,
           tc:0, ci:0, half:1};
`ifdef ADDSUB_DX_ARB_PERF_EN
    ecnt = 16'd1;
`else
    ecnt = 16'd0;
`endif
    set0(r0); set1(r1); req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b11)
      $display("FAIL pair_ready: got %b exp 11",
               {req1_ready, req0_ready});
    else n_pass++;
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    n_chk++;
    if ({dp_a, dp_b, dp_dplx} !== {16'h5612, 16'h7834, 1'b1})
      $display("FAIL pair_dp: got a=%h b=%h dplx=%b exp 5612 7834 1",
               dp_a, dp_b, dp_dplx);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_sum, rsp_tag, rsp_dplx}
        !== {1'b1, 16'hCE46, 2'b11, 1'b1})
      $display("FAIL pair_rsp: got sum=%h tag=%b exp ce46 11",
               rsp_sum, rsp_tag);
    else n_pass++;
    n_chk++;
    if (pair_cnt !== ecnt)
      $display("FAIL pair_cnt: got %0d exp %0d", pair_cnt, ecnt);
    else n_pass++;
  endtask

  task automatic test_nopair();
    rq_t r0, r1;
    ex_t e0, e1;
    do_reset();
    r0 = rnd_rq(); r0.half = 1;
    {r0.addsub, r0.sat, r0.avg, r0.tc} = 4'b0000;
    r1 = rnd_rq(); r1.half = 1;
    {r1.addsub, r1.sat, r1.avg, r1.tc} = 4'b1000;
    e0 = predict(r0, r1, 2'b01);
    e1 = predict(r0, r1, 2'b10);
    set0(r0); set1(r1); req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL nopair_ready: got %b exp 01",
               {req1_ready, req0_ready});
    else n_pass++;
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    n_chk++;
    if ({dp_a, dp_b, dp_dplx, dp_ci2} !== {e0.dpa, e0.dpb, 2'b10})
      $display("FAIL nopair_dp0: got a=%h b=%h exp %h %h",
               dp_a, dp_b, e0.dpa, e0.dpb);
    else n_pass++;
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    n_chk++;
    if ({dp_a, dp_b, dp_dplx, dp_ci1} !== {e1.dpa, e1.dpb, 2'b10})
      $display("FAIL nopair_dp1: got a=%h b=%h exp %h %h",
               dp_a, dp_b, e1.dpa, e1.dpb);
    else n_pass++;
    n_chk++;
    if ({rsp_tag, rsp_sum} !== {2'b01, e0.sum})
      $display("FAIL nopair_rsp0: got %b %h exp 01 %h",
               rsp_tag, rsp_sum, e0.sum);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({rsp_tag, rsp_sum, rsp_co2} !== {2'b10, e1.sum, e1.co2})
      $display("FAIL nopair_rsp1: got %b %h exp 10 %h",
               rsp_tag, rsp_sum, e1.sum);
    else n_pass++;
  endtask

  // Scoreboard run; the pipeline is modelled as holding at most two
  // issued ops, and the rr pointer as "prefer whoever lost last".
  task automatic run_random(input int nops, input bit stall);
    rq_t q0[$], q1[$];
    ex_t exq[$];
    ex_t e;
    rq_t h0, h1;
    int n, cyc;
    bit pref, hold, dlv;
    logic [1:0] eg, acc;
    logic [20:0] snap;
    n = 0; cyc = 0; pref = 0; hold = 0; snap = '0;
    for (int i = 0; i < nops; i++) begin
      q0.push_back(rnd_rq());
      q1.push_back(rnd_rq());
    end
    do_reset();
    while ((q0.size() != 0 || q1.size() != 0 || exq.size() != 0)
           && cyc < 3000) begin
      if (q0.size() != 0) begin
        if (!req0_valid) req0_valid = ($urandom % 4 != 0);
        set0(q0[0]);
      end else req0_valid = 0;
      if (q1.size() != 0) begin
        if (!req1_valid) req1_valid = ($urandom % 4 != 0);
        set1(q1[0]);
      end else req1_valid = 0;
      rsp_ready = stall ? !(cyc >= 3 && cyc < 6)
                        : ($urandom % 3 != 0);
      @(negedge clk);
      h0 = q0.size() != 0 ? q0[0] : '{default: 0};
      h1 = q1.size() != 0 ? q1[0] : '{default: 0};
      eg = 2'b00;
      if (n < 2 || rsp_ready) begin
        if (req0_valid && req1_valid && h0.half && h1.half &&
            {h0.addsub, h0.sat, h0.avg, h0.tc} ==
            {h1.addsub, h1.sat, h1.avg, h1.tc}) eg = 2'b11;
        else if (!pref)
          eg = req0_valid ? 2'b01 : (req1_valid ? 2'b10 : 2'b00);
        else
          eg = req1_valid ? 2'b10 : (req0_valid ? 2'b01 : 2'b00);
      end
      n_chk++;
      if ({req1_ready, req0_ready} !== eg)
        $display("FAIL rnd_ready: cyc %0d got %b exp %b n=%0d",
                 cyc, {req1_ready, req0_ready}, eg, n);
      else n_pass++;
      if (hold) begin
        n_chk++;
        if ({rsp_valid, rsp_sum, rsp_co1, rsp_co2, rsp_tag}
            !== snap)
          $display("FAIL rnd_stable: cyc %0d got %h exp %h", cyc,
            {rsp_valid, rsp_sum, rsp_co1, rsp_co2, rsp_tag}, snap);
        else n_pass++;
      end
      dlv = 0;
      if (rsp_valid && rsp_ready) begin
        dlv = 1;
        n_chk++;
        if (exq.size() == 0)
          $display("FAIL rnd_spurious: cyc %0d tag=%b exp none",
                   cyc, rsp_tag);
        else begin
          e = exq.pop_front();
          if ({rsp_sum, rsp_co1, rsp_co2, rsp_tag, rsp_dplx} !==
              {e.sum, e.co1, e.co2, e.tag, e.dplx})
            $display("FAIL rnd_rsp: cyc %0d got %h %b%b %b %b exp %h %b%b %b %b",
              cyc, rsp_sum, rsp_co1, rsp_co2, rsp_tag, rsp_dplx,
              e.sum, e.co1, e.co2, e.tag, e.dplx);
          else n_pass++;
        end
      end
      hold = rsp_valid && !rsp_ready;
      snap = {rsp_valid, rsp_sum, rsp_co1, rsp_co2, rsp_tag};
      acc = {req1_valid & req1_ready, req0_valid & req0_ready};
      if (acc != 2'b00) begin
        exq.push_back(predict(h0, h1, acc));
        if (acc != 2'b11) pref = acc[0];
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
      end
      n = n + (acc != 2'b00 ? 1 : 0) - (dlv ? 1 : 0);
      @(posedge clk); #1;
      if (acc[0]) req0_valid = 0;
      if (acc[1]) req1_valid = 0;
      cyc++;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    n_chk++;
    if (exq.size() != 0 || q0.size() != 0 || q1.size() != 0)
      $display("FAIL rnd_drain: left rsp=%0d q0=%0d q1=%0d exp 0",
               exq.size(), q0.size(), q1.size());
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0)
      $display("FAIL rnd_extra: got rsp_valid %b exp 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    run_random(12, 1'b1);
  endtask

  task automatic test_random();
    run_random(150, 1'b0);
  endtask

  task automatic test_reset_midflight();
    rq_t r;
    do_reset();
    rsp_ready = 0;
    r = rnd_rq(); r.half = 0;
    set0(r); req0_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({rsp_valid, req0_ready} !== 2'b10)
      $display("FAIL mid_full: got v=%b rdy=%b exp 1 0",
               rsp_valid, req0_ready);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_tag, dp_a, dp_dplx, dp_ci1} !== 21'h0)
      $display("FAIL mid_clear: got v=%b tag=%b a=%h exp zeros",
               rsp_valid, rsp_tag, dp_a);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0)
        $display("FAIL mid_stale: cyc %0d got %b exp 0", i,
                 rsp_valid);
      else n_pass++;
    end
    @(posedge clk); #1;
    r = rnd_rq(); r.half = 0;
    set0(r); set1(r); req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL mid_ptr: got %b exp 01",
               {req1_ready, req0_ready});
    else n_pass++;
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_sat();
    test_rr();
    test_pair();
    test_nopair();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
